rr_mux_4x1: RTL and testbench
=============================

# rr_mux_4x1

Round-robin 4-to-1 channel multiplexer. It merges four valid/ready source channels onto one registered output stream and tags each word with a 2-bit source select. The select tag uses the same encoding the 1x4 demux decodes: 00 is channel a/0, 01 is b/1, 10 is c/2, 11 is d/3. The block sits upstream of the demux, so a downstream consumer can route words or responses back to their originating channel.

## Interface
- WIDTH, default 8: data width per channel.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel word available; bit i belongs to channel i.
- in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  one-hot or zero; channel i word accepted when in_valid[i] & in_ready[i].
- out_valid  output  1  registered output word present.
- out_data  output  WIDTH  registered data.
- out_sel  output  2  registered source channel of out_data.
- out_ready  input  1  consumer accepts when out_valid & out_ready.

## Operation
- Output stage: one register holding out_valid, out_data and out_sel.
- can_load = ~out_valid | out_ready. A drain and a reload may happen in the same cycle.
- Round-robin pointer ptr, 2 bits:
  - Grant goes to the first i with in_valid[i] set, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - Grant is one-hot; it is zero when no channel is valid.
- in_ready = grant & {4{can_load}}. This is combinational from in_valid, ptr, out_valid and out_ready.
- On an accept from channel g:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= g+1 mod 4. The wrap from 3 goes to 0.
- On a drain with no accept: out_valid <= 0. out_data and out_sel hold their last values.
- No accept: ptr holds. An idle cycle never advances priority.
- Sources must hold in_valid and in_data until accepted. The block never drops or duplicates a word.
- Output rules:
  - out_data and out_sel are stable while out_valid & ~out_ready.
  - out_valid never deasserts without a handshake.
- Fairness: with all four channels continuously valid and out_ready high, the grant order is 0,1,2,3,0,...
  - Any continuously valid channel is served within 4 accepts.

## Timing
- Reset, asynchronous, applied immediately:
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready=0 while rst is high.
- Reset mid-transfer discards the held output word. After release, arbitration starts at channel 0.
- Latency: a word accepted in cycle N appears on the output in cycle N+1.
- Throughput: one word per cycle when out_ready is held high.
- Backpressure:
  - With out_valid=1 and out_ready=0, in_ready=0 on all channels.
  - In the cycle out_ready rises, one new accept happens alongside the drain.
- A channel that drops in_valid before acceptance is not granted. Its position in the priority order is unaffected.

## Structure
- Shared package mux_pkg holds:
  - localparam NUM_CH=4.
  - localparam SEL_W=2.
  - Channel encoding constants CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3, shared with the demux decode.
- Sub-module rr_arbiter_4:
  - Purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: grant[3:0], gnt_idx[1:0].
- The top level holds ptr, the output register and the handshake logic.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_sel=0 and in_ready=0 asynchronously. After release, first grant goes to channel 0.
- Single channel: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_sel=2'b10. ptr is then 3.
- Full contention: all in_valid=1, data 8'h10, 8'h11, 8'h12, 8'h13, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3. out_valid stays high continuously.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_sel are unchanged and in_ready=0000. On release, one drain and one new accept occur in the same cycle.
- Wrap and skip: ptr=3 with in_valid=4'b0011 -> grant channel 0, then ptr=1 -> grant channel 1, then ptr=2 -> wraps to grant channel 0.
- Idle: all in_valid=0 for 5 cycles -> out_valid=0 after the pending word drains, ptr is unchanged and in_ready=0000.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared channel definitions for the 4:1 round-robin mux and its companion 1:4 demux.
// The select encoding must stay identical on both sides so tagged words route back correctly.
package mux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   localparam logic [SEL_W-1:0] CH_A = 2'd0;
   localparam logic [SEL_W-1:0] CH_B = 2'd1;
   localparam logic [SEL_W-1:0] CH_C = 2'd2;
   localparam logic [SEL_W-1:0] CH_D = 2'd3;

   // Channel following c in round-robin order; 3 wraps to 0 through 2-bit overflow.
   function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
      return c + 2'd1;
   endfunction

endpackage

// File: rtl/rr_mux_4x1_if.sv
// Bus bundle for rr_mux_4x1: four source channels in, one tagged stream out.
// Handshake: a word moves on a rising clk edge exactly when valid & ready are both high; a source
// keeps valid and data steady until that edge, and ready may depend combinationally on valid.
interface rr_mux_4x1_if import mux_pkg::*; #(parameter int WIDTH = 8) ();

   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter: the first requester at or after ptr wins.
// Produces a one-hot grant plus its encoded index; both are zero when nothing requests.
module rr_arbiter_4 import mux_pkg::*; (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  gnt_idx
);

   logic             found;
   logic [SEL_W-1:0] idx;

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      // idx is 2 bits wide, so ptr + k wraps modulo 4 on its own.
      for (int k = 0; k < NUM_CH; k++) begin
         idx = ptr + SEL_W'(k);
         if (!found && req[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/rr_mux_4x1.sv
// Round-robin 4:1 channel mux with a single registered output stage tagged by source select.
// Priority advances only on an accept, to the channel after the one just served.
module rr_mux_4x1 import mux_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   rr_mux_4x1_if.slave      bus,
   output logic [SEL_W-1:0] dbg_ptr
);

   logic [SEL_W-1:0]  ptr;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  gnt_idx;
   logic              can_load;
   logic              accept;
   logic              drain;
   logic              valid_q;
   logic [WIDTH-1:0]  data_q;
   logic [SEL_W-1:0]  sel_q;

   rr_arbiter_4 u_arb (
      .req     (bus.in_valid),
      .ptr     (ptr),
      .grant   (grant),
      .gnt_idx (gnt_idx)
   );

   // The output register may be reloaded in the same cycle it drains.
   assign can_load     = ~valid_q | bus.out_ready;
   assign bus.in_ready = rst ? '0 : (grant & {NUM_CH{can_load}});
   assign accept       = |bus.in_ready;
   assign drain        = valid_q & bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= CH_A;
         ptr     <= CH_A;
      end else if (accept) begin
         valid_q <= 1'b1;
         data_q  <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
         sel_q   <= gnt_idx;
         ptr     <= next_ch(gnt_idx);
      end else if (drain) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
   assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Bench for rr_mux_4x1: directed scenarios plus randomized traffic against a queue-based
// round-robin reference; the monitor pops expected {sel,data} words as the DUT delivers them.
module tb_rr_mux_4x1;
   import mux_pkg::*;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_ptr;

   rr_mux_4x1_if #(.WIDTH(W)) bus ();

   rr_mux_4x1 #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .dbg_ptr (dbg_ptr)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [W+1:0] exp_q[$];
   localparam logic [1:0] CODES [NUM_CH] = '{CH_A, CH_B, CH_C, CH_D};

   // Reference state: whose turn it is and whether a word is sitting at the output.
   int m_ptr = 0;
   bit m_ov  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int p, input logic [3:0] v);
      for (int k = 0; k < NUM_CH; k++)
         if (v[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
      return -1;
   endfunction

   // Monitor / scoreboard at the falling edge, where all inputs are settled.
   always @(negedge clk) begin
      logic [3:0]   exp_rdy;
      logic [W+1:0] e;
      int           g;
      bit           can_load;
      if (rst) begin
         m_ptr = 0;
         m_ov  = 1'b0;
         exp_q.delete();
      end else begin
         check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
         check("ptr", {30'b0, dbg_ptr}, m_ptr);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out_word: got %0h expected none", {bus.out_sel, bus.out_data});
            end else begin
               e = exp_q.pop_front();
               check("out_word", {22'b0, bus.out_sel, bus.out_data}, {22'b0, e});
            end
         end
         can_load = !m_ov || bus.out_ready;
         g = pick(m_ptr, bus.in_valid);
         exp_rdy = (g >= 0 && can_load) ? 4'(1 << g) : 4'b0;
         check("in_ready", {28'b0, bus.in_ready}, {28'b0, exp_rdy});
         if (exp_rdy != 4'b0) begin
            exp_q.push_back({CODES[g], bus.in_data[g*W +: W]});
            m_ptr = (g + 1) % NUM_CH;
            m_ov  = 1'b1;
         end else if (m_ov && bus.out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input bit v, input logic [W-1:0] d);
      bus.in_valid[i]       = v;
      bus.in_data[i*W +: W] = d;
   endtask

   logic [3:0] acc;

   initial begin
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (3) step();

      // Reset state, with requests present to show in_ready is held off.
      bus.in_valid = 4'hF;
      #1;
      check("rst_out_valid", {31'b0, bus.out_valid}, 0);
      check("rst_out_data", {24'b0, bus.out_data}, 0);
      check("rst_out_sel", {30'b0, bus.out_sel}, 0);
      check("rst_in_ready", {28'b0, bus.in_ready}, 0);
      check("rst_ptr", {30'b0, dbg_ptr}, 0);
      bus.in_valid = '0;
      step();
      rst = 1'b0;

      // Full contention: order 0,1,2,3,0,1,2,3 with continuous output.
      for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 8'h10 + 8'(i));
      bus.out_ready = 1'b1;
      repeat (8) step();
      bus.in_valid = '0;
      check("contend_ptr", {30'b0, dbg_ptr}, 0);
      step();

      // Single channel 2.
      set_ch(2, 1'b1, 8'hA5);
      step();
      bus.in_valid = '0;
      check("single_data", {24'b0, bus.out_data}, 32'hA5);
      check("single_sel", {30'b0, bus.out_sel}, 2);
      check("single_ptr", {30'b0, dbg_ptr}, 3);

      // Wrap and skip from ptr=3 with channels 0 and 1 requesting.
      set_ch(0, 1'b1, 8'h20);
      set_ch(1, 1'b1, 8'h21);
      repeat (3) step();
      bus.in_valid = '0;
      check("wrap_sel", {30'b0, bus.out_sel}, 0);
      check("wrap_ptr", {30'b0, dbg_ptr}, 1);
      repeat (2) step();

      // Backpressure: hold a word while out_ready is low.
      bus.out_ready = 1'b0;
      set_ch(1, 1'b1, 8'h55);
      set_ch(3, 1'b1, 8'h77);
      step();
      set_ch(1, 1'b0, 8'h00);
      repeat (3) begin
         step();
         check("bp_in_ready", {28'b0, bus.in_ready}, 0);
         check("bp_data", {24'b0, bus.out_data}, 32'h55);
         check("bp_sel", {30'b0, bus.out_sel}, 1);
      end
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = '0;
      check("bp_reload_valid", {31'b0, bus.out_valid}, 1);
      check("bp_reload_data", {24'b0, bus.out_data}, 32'h77);
      check("bp_reload_sel", {30'b0, bus.out_sel}, 3);

      // Idle: word drains, priority does not move.
      repeat (5) step();
      check("idle_valid", {31'b0, bus.out_valid}, 0);
      check("idle_ptr", {30'b0, dbg_ptr}, 0);
      check("idle_in_ready", {28'b0, bus.in_ready}, 0);

      // Asynchronous reset while a word is held.
      for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 8'($urandom_range(0, 255)));
      bus.out_ready = 1'b0;
      step();
      #1;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'b0, bus.out_valid}, 0);
      check("arst_out_sel", {30'b0, bus.out_sel}, 0);
      check("arst_in_ready", {28'b0, bus.in_ready}, 0);
      step();
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = '0;
      check("arst_first_sel", {30'b0, bus.out_sel}, 0);
      repeat (2) step();

      // Randomized traffic: sources hold words until accepted, occasionally withdraw.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i] || !bus.in_valid[i])
               set_ch(i, ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)));
            else if ($urandom_range(0, 31) == 0)
               bus.in_valid[i] = 1'b0;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.in_valid & bus.in_ready;
         @(posedge clk);
         #1;
      end

      // Drain everything still in flight.
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      repeat (3) step();
      check("final_queue_empty", exp_q.size(), 0);
      check("final_out_valid", {31'b0, bus.out_valid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
